// File: rtl/lane_det_pkg.sv
// Shared types and helpers for the lane-detection video link.
// Counter widths derive from per-instance image sizes via cnt_w().
package lane_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } tx_state_t;

  // Counter width for a range of n values, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_axis_tx_if.sv
// AXI4-Stream video bus: one pixel per beat, tuser marks SOF, tlast marks end of row.
interface video_axis_tx_if #(
  parameter int AXI_WIDTH = 24
) ();
  logic [AXI_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic                 tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/video_axis_tx_fifo.sv
// Synchronous FIFO with registered read port and wrap-bit pointers.
// rd_data updates on the edge that pops, so data lands one cycle after pop.
module axis_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the same edge frees a slot
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop) begin
        rd_data <= mem[rptr[AW-1:0]];
        rptr    <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/video_axis_tx.sv
// AXI4-Stream video master: buffers raster pixels and emits exactly one framed
// frame per start, with tuser on the first pixel and tlast at each row end.
module video_axis_tx
  import lane_det_pkg::*;
#(
  parameter int IMG_LENGTH = 416,
  parameter int IMG_WIDTH  = 416,
  parameter int AXI_WIDTH  = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  input  logic [AXI_WIDTH-1:0] pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  video_axis_tx_if.master      m_axi_video
);
  localparam int COL_W     = cnt_w(IMG_WIDTH);
  localparam int ROW_W     = cnt_w(IMG_LENGTH);
  localparam int PIX_CNT_W = $clog2(IMG_LENGTH*IMG_WIDTH+1);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [COL_W-1:0]     LAST_COL = COL_W'(IMG_WIDTH-1);
  localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(IMG_LENGTH-1);
  localparam logic [PIX_CNT_W-1:0] TOTAL    = PIX_CNT_W'(IMG_LENGTH*IMG_WIDTH);

  tx_state_t            state;
  logic [PIX_CNT_W-1:0] in_cnt;
  logic [COL_W-1:0]     col, col_nx;
  logic [ROW_W-1:0]     row, row_nx;
  logic                 rd_vld;
  logic                 tvalid_q, tlast_q, tuser_q;
  logic [AXI_WIDTH-1:0] tdata_q;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AXI_WIDTH-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 hs, load_out, last_beat;

  axis_sync_fifo #(.WIDTH(AXI_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (pix_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pix_ready = (state == STREAM) && !fifo_full && (in_cnt < TOTAL);
  assign fifo_push = pix_valid && pix_ready;

  assign hs        = tvalid_q && m_axi_video.tready;
  // rd_data is a holding stage between FIFO and output register; both advance
  // together so a stalled sink never loses a popped word
  assign load_out  = rd_vld && (!tvalid_q || hs);
  assign fifo_pop  = !fifo_empty && (!rd_vld || load_out);
  assign last_beat = hs && (col == LAST_COL) && (row == LAST_ROW);

  // Position of the beat presented after this edge
  always_comb begin
    col_nx = col;
    row_nx = row;
    if (hs) begin
      if (col == LAST_COL) begin
        col_nx = '0;
        row_nx = row + ROW_W'(1);
      end else begin
        col_nx = col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      in_cnt     <= '0;
      col        <= '0;
      row        <= '0;
      rd_vld     <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= STREAM;
          busy   <= 1'b1;
          in_cnt <= '0;
          col    <= '0;
          row    <= '0;
        end
        STREAM: begin
          if (fifo_push) in_cnt <= in_cnt + PIX_CNT_W'(1);
          col <= col_nx;
          row <= row_nx;
          if (last_beat) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (fifo_pop)      rd_vld <= 1'b1;
      else if (load_out) rd_vld <= 1'b0;

      if (load_out) begin
        tvalid_q <= 1'b1;
        tdata_q  <= fifo_rd_data;
        tlast_q  <= (col_nx == LAST_COL);
        tuser_q  <= (col_nx == '0) && (row_nx == '0);
      end else if (hs) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_count <= CNT_W'(FIFO_DEPTH));
  end

  assign m_axi_video.tvalid = tvalid_q;
  assign m_axi_video.tdata  = tdata_q;
  assign m_axi_video.tlast  = tlast_q;
  assign m_axi_video.tuser  = tuser_q;

endmodule

// File: tb/tb_video_axis_tx.sv
// Bench for video_axis_tx: table of frame scenarios plus reset/idle sequences,
// beats scored against a queue of accepted pixels and raster-position rules.
module tb_video_axis_tx;
  localparam int IMG_W = 4;
  localparam int IMG_L = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 24;
  localparam int NPIX  = IMG_W * IMG_L;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          busy, frame_done, pix_ready;
  logic          pix_valid = 1'b0;
  logic [AW-1:0] pix_data  = '0;

  video_axis_tx_if #(.AXI_WIDTH(AW)) vif ();

  video_axis_tx #(
    .IMG_LENGTH(IMG_L), .IMG_WIDTH(IMG_W), .AXI_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .m_axi_video(vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            pm;        // producer: 0 always, 1 one-in-three, 2 random
    int            rm;        // sink: 0 ready, 1 toggle, 2 random
    bit            rnd;
    logic [AW-1:0] base;
    int            nsrc;
    int            stall;     // cycles of tready=0 before the rm pattern
    bit            sb;        // pulse start in STREAM and in DONE
    bit            lat;
    int            exp_beats;
    int            exp_done;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, beat_idx = 0, src_idx = 0, src_n = 0, fd_cnt = 0;
  int first_acc = -1, first_vld = -1;
  int prod_mode = 0, rdy_mode = 0;
  bit prod_en = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] prev_d;
  logic [1:0]    prev_s;
  logic [AW-1:0] src [16];
  logic [AW-1:0] acc_q [$];
  vec_t vt [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},       32'(busy),        32'd0);
    check({tag, "_frame_done"}, 32'(frame_done),  32'd0);
    check({tag, "_pix_ready"},  32'(pix_ready),   32'd0);
    check({tag, "_tvalid"},     32'(vif.tvalid),  32'd0);
    check({tag, "_tdata"},      32'(vif.tdata),   32'd0);
    check({tag, "_tlast"},      32'(vif.tlast),   32'd0);
    check({tag, "_tuser"},      32'(vif.tuser),   32'd0);
  endtask

  always @(posedge clk) cyc++;

  // Producer and sink drivers
  always @(posedge clk) begin
    #1;
    if (prod_en) begin
      if (src_idx < src_n) begin
        pix_data = src[src_idx];
        case (prod_mode)
          0:       pix_valid = 1'b1;
          1:       pix_valid = (cyc % 3 == 0);
          default: pix_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        pix_valid = 1'b0;
      end
    end
    case (rdy_mode)
      0:       vif.tready = 1'b1;
      1:       vif.tready = !vif.tready;
      2:       vif.tready = 1'($urandom_range(0, 1));
      default: vif.tready = 1'b0;
    endcase
  end

  // Reference model: beat k of a frame carries the k-th accepted pixel,
  // SOF on k==0 and end-of-row on every IMG_W-th beat
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (pix_valid && pix_ready) begin
        if (first_acc < 0) first_acc = cyc;
        acc_q.push_back(pix_data);
        src_idx++;
      end
      if (prev_stall) begin
        check("stall_tvalid", 32'(vif.tvalid), 32'd1);
        check("stall_tdata",  32'(vif.tdata), 32'(prev_d));
        check("stall_side",   32'({vif.tlast, vif.tuser}), 32'(prev_s));
      end
      if (vif.tvalid && first_vld < 0) first_vld = cyc;
      if (vif.tvalid && vif.tready) begin
        if (beat_idx < acc_q.size()) begin
          check("beat_tdata", 32'(vif.tdata), 32'(acc_q[beat_idx]));
          check("beat_tuser", 32'(vif.tuser), 32'(beat_idx == 0));
          check("beat_tlast", 32'(vif.tlast), 32'((beat_idx % IMG_W) == IMG_W - 1));
        end else begin
          check("extra_beat", 32'(beat_idx), 32'(acc_q.size()));
        end
        beat_idx++;
      end
      prev_stall = vif.tvalid && !vif.tready;
      prev_d     = vif.tdata;
      prev_s     = {vif.tlast, vif.tuser};
    end
  end

  task automatic run_frame(input vec_t v);
    bit done;
    int exp_acc;
    acc_q.delete();
    beat_idx = 0; src_idx = 0; fd_cnt = 0; first_acc = -1; first_vld = -1;
    src_n = v.nsrc;
    for (int i = 0; i < v.nsrc; i++) src[i] = v.rnd ? AW'($urandom) : v.base + AW'(i);
    prod_mode = v.pm;
    rdy_mode  = (v.stall > 0) ? 3 : v.rm;
    prod_en   = 1'b1;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    check({v.name, "_busy_after_start"},  32'(busy),      32'd1);
    check({v.name, "_ready_after_start"}, 32'(pix_ready), 32'd1);
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      @(negedge clk);
      check({v.name, "_fill_pix_ready"}, 32'(pix_ready), 32'd0);
      check({v.name, "_fill_held"}, 32'(src_idx >= DEPTH && src_idx < NPIX), 32'd1);
      check({v.name, "_fill_tvalid"}, 32'(vif.tvalid), 32'd1);
      check({v.name, "_fill_no_beat"}, 32'(beat_idx), 32'd0);
      rdy_mode = v.rm;
    end
    if (v.sb) begin
      repeat (3) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      check({v.name, "_busy_after_stray_start"}, 32'(busy), 32'd1);
    end
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #2;
      if (frame_done) begin
        done = 1'b1;
        if (v.sb) start = 1'b1;
      end
    end
    check({v.name, "_frame_timeout"}, 32'(done), 32'd1);
    @(posedge clk); #2 start = 1'b0;
    check({v.name, "_busy_end"}, 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    exp_acc = (v.nsrc > NPIX) ? NPIX : v.nsrc;
    check({v.name, "_beats"},      32'(beat_idx),   32'(v.exp_beats));
    check({v.name, "_frame_done"}, 32'(fd_cnt),     32'(v.exp_done));
    check({v.name, "_accepted"},   32'(src_idx),    32'(exp_acc));
    check({v.name, "_idle_busy"},  32'(busy),       32'd0);
    check({v.name, "_idle_ready"}, 32'(pix_ready),  32'd0);
    check({v.name, "_idle_tvalid"},32'(vif.tvalid), 32'd0);
    if (v.lat) check({v.name, "_latency"}, 32'(first_vld - first_acc), 32'd3);
    prod_en   = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    vt[0] = '{name:"clean",      pm:0, rm:0, rnd:0, base:24'h01, nsrc:8, stall:0,  sb:0, lat:1, exp_beats:8, exp_done:1};
    vt[1] = '{name:"bp_toggle",  pm:0, rm:1, rnd:0, base:24'h31, nsrc:8, stall:0,  sb:0, lat:0, exp_beats:8, exp_done:1};
    vt[2] = '{name:"gaps",       pm:1, rm:0, rnd:0, base:24'h41, nsrc:8, stall:0,  sb:0, lat:0, exp_beats:8, exp_done:1};
    vt[3] = '{name:"stray9",     pm:1, rm:1, rnd:0, base:24'h51, nsrc:9, stall:0,  sb:0, lat:0, exp_beats:8, exp_done:1};
    vt[4] = '{name:"fill",       pm:0, rm:0, rnd:0, base:24'h61, nsrc:8, stall:20, sb:0, lat:0, exp_beats:8, exp_done:1};
    vt[5] = '{name:"start_busy", pm:1, rm:0, rnd:0, base:24'h71, nsrc:8, stall:0,  sb:1, lat:0, exp_beats:8, exp_done:1};
    for (int i = 6; i < 10; i++)
      vt[i] = '{name:"rand", pm:2, rm:2, rnd:1, base:24'h0, nsrc:9, stall:0, sb:0, lat:0, exp_beats:8, exp_done:1};

    vif.tready = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_reset("por");
    rst = 1'b0;

    // Pixels offered while idle must not be taken
    src[0] = 24'h99; src_n = 1; src_idx = 0; prod_mode = 0; prod_en = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      check("idle_pix_ready", 32'(pix_ready), 32'd0);
      check("idle_tvalid",    32'(vif.tvalid), 32'd0);
    end
    check("idle_accepted", 32'(src_idx), 32'd0);
    prod_en = 1'b0; pix_valid = 1'b0;

    for (int i = 0; i < 10; i++) run_frame(vt[i]);

    // Reset in the middle of a frame, then a fresh frame
    acc_q.delete(); beat_idx = 0; src_idx = 0;
    for (int i = 0; i < 8; i++) src[i] = 24'h21 + AW'(i);
    src_n = 8; prod_mode = 0; rdy_mode = 0; prod_en = 1'b1;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int c = 0; c < 100 && beat_idx < 5; c++) @(negedge clk);
    check("midrst_reached_5", 32'(beat_idx >= 5), 32'd1);
    @(posedge clk); #2 rst = 1'b1; prod_en = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    check_reset("midrst");
    run_frame('{name:"after_rst", pm:0, rm:0, rnd:0, base:24'h11, nsrc:8, stall:0, sb:0, lat:1, exp_beats:8, exp_done:1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
